prog_loader: RTL

//  Boot-time program loader upstream of the 19-bit CPU core. Accepts a byte stream

---
 rtl/prog_loader.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that assembles 19-bit instruction words from a byte
// stream, writes them to instruction memory and releases the CPU reset once the
// image checksum verifies. Stream errors latch a sticky error and keep the CPU in reset.
module prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  // The index must count one past the largest address so it can be compared with N.
  localparam int IDX_W     = ADDR_WIDTH + 1;
  localparam int MAX_WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_COUNT = 3'd0,
    S_B0    = 3'd1,
    S_B1    = 3'd2,
    S_B2    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2:0]            b0_q, b0_d;
  logic [7:0]            b1_q, b1_d;
  logic [7:0]            xor_q, xor_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept_state_s;
  logic                  in_ready_s;
  logic                  xfer_s;
  logic                  too_big_s;
  logic [IDX_W-1:0]      idx_inc_s;
  logic                  last_word_s;

  // Decode which states take a stream byte; reset always blocks acceptance.
  always_comb begin
    accept_state_s = 1'b0;
    case (state_q)
      S_COUNT, S_B0, S_B1, S_B2, S_CSUM: accept_state_s = 1'b1;
      default:                           accept_state_s = 1'b0;
    endcase
    in_ready_s  = !reset && accept_state_s;
    xfer_s      = in_valid && in_ready_s;
    too_big_s   = (32'(in_data) > 32'(MAX_WORDS));
    idx_inc_s   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    last_word_s = (32'(idx_inc_s) == 32'(n_q));
  end

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    xor_d        = xor_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      S_COUNT: begin
        if (xfer_s) begin
          n_d   = in_data;
          xor_d = in_data;
          idx_d = {IDX_W{1'b0}};
          if (in_data == 8'd0) begin
            state_d = S_CSUM;
          end else if (too_big_s) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_B0;
          end
        end else begin
          state_d = S_COUNT;
        end
      end

      S_B0: begin
        if (xfer_s) begin
          if (in_data[7:3] != 5'd0) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            b0_d    = in_data[2:0];
            xor_d   = xor_q ^ in_data;
            state_d = S_B1;
          end
        end else begin
          state_d = S_B0;
        end
      end

      S_B1: begin
        if (xfer_s) begin
          b1_d    = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_B2;
        end else begin
          state_d = S_B1;
        end
      end

      S_B2: begin
        if (xfer_s) begin
          imem_wdata_d = DATA_WIDTH'({b0_q, b1_q, in_data});
          imem_addr_d  = idx_q[ADDR_WIDTH-1:0];
          imem_we_d    = 1'b1;
          xor_d        = xor_q ^ in_data;
          state_d      = S_WRITE;
        end else begin
          state_d = S_B2;
        end
      end

      // Single write cycle: the strobe drops and the index advances on exit.
      S_WRITE: begin
        imem_we_d = 1'b0;
        idx_d     = idx_inc_s;
        if (last_word_s) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_B0;
        end
      end

      S_CSUM: begin
        if (xfer_s) begin
          if (in_data == xor_q) begin
            state_d     = S_DONE;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end else begin
          state_d = S_CSUM;
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      S_ERR: begin
        state_d     = S_ERR;
        cpu_reset_d = 1'b1;
      end

      // An undecodable state is treated as a fault that keeps the CPU held.
      default: begin
        state_d     = S_ERR;
        error_d     = 1'b1;
        cpu_reset_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset; memory contents are untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_COUNT;
      n_q          <= 8'd0;
      idx_q        <= {IDX_W{1'b0}};
      b0_q         <= 3'd0;
      b1_q         <= 8'd0;
      xor_q        <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= {ADDR_WIDTH{1'b0}};
      imem_wdata_q <= {DATA_WIDTH{1'b0}};
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      xor_q        <= xor_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
